// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit CLA slice.
//   state_t : FSM state encoding (2-bit)
//   NIB_W   : width of one nibble processed per clock
//   clog2   : width helper used to size the nibble counter (never below 1)
package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Returns the number of bits needed to count to n-1, with a floor of 1 so
  // a single-nibble adder still gets a legal counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry look-ahead adder slice.
// Ports:
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : sum nibble
//   cout : carry out of bit 3
//   g, p : per-bit generate / propagate
//   c    : c[i] is the carry into bit i+1 (c[2] feeds bit 3, used for overflow)
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic [3:0] g,
  output logic [3:0] p,
  output logic [2:0] c
);

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded to two logic levels instead of rippling.
  assign c[0] = g[0] | (p[0] & cin);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c[2], c[1], c[0], cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one nibble per clock through a single 4-bit CLA slice,
// least-significant nibble first, with a start/busy/done handshake.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, only honoured in IDLE
//   a, b, cin     : operands, captured on the accepted start edge
//   busy          : high while the nibbles are being added
//   done          : one-cycle pulse when sum/cout/ovf are final
//   sum, cout     : WIDTH-bit result and carry out of the MSB
//   ovf           : two's-complement overflow
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one nibble per clock
// DONE  | result final, done pulse
module nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = clog2(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  generate
    if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDX_W-1:0] r_idx;

  logic [3:0] w_s;
  logic       w_cout;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [2:0] w_c;
  logic       w_unused_gp;

  cla4_slice u_slice (
    .a    (r_a[3:0]),
    .b    (r_b[3:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout),
    .g    (w_g),
    .p    (w_p),
    .c    (w_c)
  );

  // Generate/propagate are exported by the slice for reuse but not needed here.
  assign w_unused_gp = ^{w_g, w_p};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // New nibble enters at the top; after NIB shifts the LSB nibble
          // has reached bit 0.
          r_sum   <= WIDTH'({w_s, r_sum} >> NIB_W);
          r_carry <= w_cout;
          r_a     <= r_a >> NIB_W;
          r_b     <= r_b >> NIB_W;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            r_cout  <= w_cout;
            r_ovf   <= w_cout ^ w_c[2];
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int n_vec  = 0;
  int n_err  = 0;
  int n_push = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer addition; overflow from the sign rule
  // (same-sign operands giving a result of the other sign).
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    logic [W:0] s;
    s      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    e.cyc  = 0;
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation,
  // including the cycle in which it was due.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (q.size() == 0) begin
        check("spurious_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum",        32'(sum),  32'(e.sum));
        check("cout",       32'(cout), 32'(e.cout));
        check("ovf",        32'(ovf),  32'(e.ovf));
        check("done_cycle", 32'(cyc),  32'(e.cyc));
      end
    end
  end

  // Issues one operation from IDLE and returns once the DUT is back in IDLE.
  // Operands are scrambled while busy to prove they are not re-sampled.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic hold, input logic ff_garbage);
    exp_t e;
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    e     = model(x, y, c);
    e.cyc = cyc + NIB;
    q.push_back(e);
    n_push++;
    start = hold;
    for (int i = 0; i < NIB; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      a   = ff_garbage ? '1 : W'($urandom);
      b   = ff_garbage ? '1 : W'($urandom);
      cin = 1'($urandom);
      @(posedge clk); #1;
    end
    check("busy_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
    // start held high throughout, operands forced to all-ones while busy
    do_op(16'h0003, 16'h0004, 1'b0, 1'b1, 1'b1);
    do_op(16'h0102, 16'h0304, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;

    // Abort in the second RUN cycle: no done may follow.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    repeat (NIB + 2) @(posedge clk);
    #1;
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
    end
    start = 1'b0;

    repeat (NIB + 3) @(posedge clk);
    #1;
    check("pending_results", 32'(q.size()), 32'd0);
    check("done_count",      32'(n_done),   32'(n_push));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
